// File: rtl/bb_sweeper_if.sv
// Handshake and stage-facing signals of the bb_sweeper characteriser.
// master = sweeper side, slave = host/stage side.
interface bb_sweeper_if;
    logic       start;
    logic       abort;
    logic       u_in;
    logic       q_out;
    logic       i_out;
    logic       f_out;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       unstable;
    logic [7:0] expect_in;
    logic       mismatch;

    modport master (
        input  start, abort, u_in, expect_in,
        output q_out, i_out, f_out, busy, done, table_out, unstable, mismatch
    );

    modport slave (
        output start, abort, u_in, expect_in,
        input  q_out, i_out, f_out, busy, done, table_out, unstable, mismatch
    );
endinterface

// File: rtl/bb_sweeper.sv
// Sweeps {q,i,f} over a 3-input stage and captures u into an 8-bit truth table,
// repeating PASSES times to flag unstable outputs. BB_SWEEP_CHECK_EN builds the expect_in comparator.
module bb_sweeper #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic         clk,
    input  logic         reset,
    bb_sweeper_if.master bus
);
    localparam int            SW          = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);
    localparam logic [3:0]    PASS_LAST   = 4'(PASSES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    idx;
    logic [SW-1:0] settle;
    logic [3:0]    pass;
    logic [7:0]    table_r;
    logic          unstable_r;
    logic          mismatch_r;

    logic       accept;
    logic       drv_abort;
    logic       sample;
    logic       final_sample;
    logic [7:0] table_nxt;

    assign accept       = (state == IDLE) && bus.start && !bus.abort;
    assign drv_abort    = (state == DRIVE) && bus.abort;
    assign sample       = (state == DRIVE) && !bus.abort && (settle == SETTLE_LAST);
    assign final_sample = sample && (idx == 3'd7) && (pass == PASS_LAST);

    // Table as it will stand after this edge; used by the comparator on the final sample.
    always_comb begin
        table_nxt = table_r;
        if (pass == 4'd0) begin
            table_nxt[idx] = bus.u_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DRIVE;
            DRIVE: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (final_sample) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.q_out = 1'b0;
        bus.i_out = 1'b0;
        bus.f_out = 1'b0;
        case (state)
            DRIVE: begin
                bus.busy                      = 1'b1;
                {bus.q_out, bus.i_out, bus.f_out} = idx;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            settle     <= '0;
            pass       <= '0;
            table_r    <= '0;
            unstable_r <= 1'b0;
        end else if (accept) begin
            idx        <= '0;
            settle     <= '0;
            pass       <= '0;
            table_r    <= '0;
            unstable_r <= 1'b0;
        end else if (drv_abort) begin
            idx     <= '0;
            settle  <= '0;
            pass    <= '0;
            table_r <= '0;
        end else if (state == DRIVE) begin
            if (sample) begin
                settle <= '0;
                idx    <= idx + 3'd1;
                if (idx == 3'd7) begin
                    pass <= pass + 4'd1;
                end
                // Later passes only compare; the table keeps the pass-0 capture.
                if (pass == 4'd0) begin
                    table_r <= table_nxt;
                end else if (bus.u_in != table_r[idx]) begin
                    unstable_r <= 1'b1;
                end
            end else begin
                settle <= settle + SW'(1);
            end
        end
    end

`ifdef BB_SWEEP_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset || accept || drv_abort) begin
            mismatch_r <= 1'b0;
        end else if (final_sample) begin
            mismatch_r <= (table_nxt != bus.expect_in);
        end
    end
`else
    logic [7:0] unused_expect;
    assign unused_expect = bus.expect_in;
    assign mismatch_r    = 1'b0;
`endif

    assign bus.table_out = table_r;
    assign bus.unstable  = unstable_r;
    assign bus.mismatch  = mismatch_r;
endmodule

// File: tb/tb_bb_sweeper.sv
// Scoreboard bench for bb_sweeper: a default instance and a PASSES=3/SETTLE_CYCLES=0 instance
// driving a modelled 3-input stage u = ~(q & f & ~i).
module tb_bb_sweeper;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bb_sweeper_if ifa ();
    bb_sweeper_if ifb ();

    bb_sweeper dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    bb_sweeper #(.SETTLE_CYCLES(0), .PASSES(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    function automatic logic stage_u(input logic [2:0] n);
        return ~(n[2] & n[0] & ~n[1]);
    endfunction

    logic [2:0] idx_a, idx_b;
    assign idx_a = {ifa.q_out, ifa.i_out, ifa.f_out};
    assign idx_b = {ifb.q_out, ifb.i_out, ifb.f_out};

    // Instance B sees a glitch at index 2 on its second visit only (pass 1).
    int visits2 = 0;
    always @(posedge clk) begin
        if (!ifb.busy) visits2 <= 0;
        else if (idx_b == 3'd2) visits2 <= visits2 + 1;
    end

    assign ifa.u_in = stage_u(idx_a);
    assign ifb.u_in = stage_u(idx_b) ^ (ifb.busy && idx_b == 3'd2 && visits2 == 1);

    logic       sel = 1'b0;
    logic       cur_busy, cur_done, cur_unst, cur_mis;
    logic [7:0] cur_tab;
    logic [2:0] cur_idx;
    assign cur_busy = sel ? ifb.busy      : ifa.busy;
    assign cur_done = sel ? ifb.done      : ifa.done;
    assign cur_unst = sel ? ifb.unstable  : ifa.unstable;
    assign cur_mis  = sel ? ifb.mismatch  : ifa.mismatch;
    assign cur_tab  = sel ? ifb.table_out : ifa.table_out;
    assign cur_idx  = sel ? idx_b         : idx_a;

    typedef struct {
        logic [7:0] tab;
        logic       unst;
        logic       mis;
        int         lat;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel) ifb.start = v; else ifa.start = v;
    endtask

    task automatic drive_expect(input logic [7:0] v);
        if (sel) ifb.expect_in = v; else ifa.expect_in = v;
    endtask

    task automatic run(input logic s, input logic [7:0] exp_in,
                       input logic [7:0] exp_tab, input logic exp_unst);
        exp_t e;
        int   lat;
        sel = s;
        @(negedge clk);
        drive_start(1'b1);
        drive_expect(exp_in);
        e.tab  = exp_tab;
        e.unst = exp_unst;
`ifdef BB_SWEEP_CHECK_EN
        e.mis  = (exp_tab != exp_in);
`else
        e.mis  = 1'b0;
`endif
        e.lat  = 24;
        sb.push_back(e);
        @(negedge clk);
        drive_start(1'b0);
        check("busy_after_start", cur_busy, 1);
        check("idx0_after_start", cur_idx, 0);
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            if (cur_done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        check("done_latency", lat, e.lat);
        check("table_at_done", cur_tab, e.tab);
        check("unstable_at_done", cur_unst, e.unst);
        check("mismatch_at_done", cur_mis, e.mis);
        check("busy_in_done", cur_busy, 0);
        @(negedge clk);
        check("done_one_cycle", cur_done, 0);
        check("idx_zero_idle", cur_idx, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ndone;
        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.expect_in = 8'h00;
        ifb.start = 1'b0; ifb.abort = 1'b0; ifb.expect_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", ifa.busy, 0);
        check("rst_done", ifa.done, 0);
        check("rst_idx", idx_a, 0);
        check("rst_table", ifa.table_out, 8'h00);
        check("rst_unstable", ifa.unstable, 0);
        check("rst_mismatch", ifa.mismatch, 0);
        check("rst_b_busy", ifb.busy, 0);
        reset = 1'b0;
        @(negedge clk);

        run(1'b0, 8'hDF, 8'hDF, 1'b0);
        run(1'b0, 8'hFF, 8'hDF, 1'b0);
        repeat (3) @(negedge clk);
        check("table_hold_idle", ifa.table_out, 8'hDF);
`ifdef BB_SWEEP_CHECK_EN
        check("mismatch_hold_idle", ifa.mismatch, 1);
`else
        check("mismatch_hold_idle", ifa.mismatch, 0);
`endif

        run(1'b1, 8'hDF, 8'hDF, 1'b1);

        // start held high across a whole run
        sel = 1'b0;
        ifa.start = 1'b1;
        ifa.expect_in = 8'hDF;
        ndone = 0;
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            if (ifa.done) ndone++;
            if (k == 25) check("idle_after_done_held", ifa.busy, 0);
            if (k == 26) check("restart_when_held", ifa.busy, 1);
            @(negedge clk);
        end
        check("one_done_held", ndone, 1);
        ifa.start = 1'b0;
        ifa.abort = 1'b1;
        @(negedge clk);
        ifa.abort = 1'b0;
        check("abort_cleanup_busy", ifa.busy, 0);

        // abort while index 4 is presented
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (idx_a == 3'd4) break;
            @(negedge clk);
        end
        check("reached_idx4", idx_a, 4);
        check("partial_table", ifa.table_out, 8'h0F);
        ifa.abort = 1'b1;
        @(negedge clk);
        ifa.abort = 1'b0;
        check("abort_busy", ifa.busy, 0);
        check("abort_done", ifa.done, 0);
        check("abort_table", ifa.table_out, 8'h00);
        check("abort_idx", idx_a, 0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (ifa.done) ndone++;
        end
        check("no_done_after_abort", ndone, 0);

        // abort and start together in IDLE
        ifa.start = 1'b1;
        ifa.abort = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        ifa.abort = 1'b0;
        check("abort_beats_start", ifa.busy, 0);

        // reset mid-sweep together with start/abort
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (10) @(negedge clk);
        check("midsweep_busy", ifa.busy, 1);
        reset = 1'b1;
        ifa.start = 1'b1;
        ifa.abort = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", ifa.busy, 0);
        check("rst_mid_done", ifa.done, 0);
        check("rst_mid_idx", idx_a, 0);
        check("rst_mid_table", ifa.table_out, 8'h00);
        check("rst_mid_b_unstable", ifb.unstable, 0);
        check("rst_mid_b_table", ifb.table_out, 8'h00);
        reset = 1'b0;
        ifa.start = 1'b0;
        ifa.abort = 1'b0;
        @(negedge clk);
        check("rst_mid_idle", ifa.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
